rob_drain_ctrl: RTL and testbench

- In-order drain controller for the reorder buffer (rob). Pops the head packet whenever the ROB reports it valid and presents it on a single-register valid/ready output stream.
- Re-bases the ROB window at start-up.
- Declares the head PID lost and skips past it when later packets are buffered but the head has not arrived within p_TIMEOUT cycles.
- Sits between the rob instance and the downstream packet consumer.

---
 rtl/rob_drain_ctrl.sv | 134 +++++++++++++
 tb/tb_rob_drain_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_drain_ctrl.sv
// In-order drain controller for the reorder buffer: pops the head packet into a
// one-entry valid/ready output register, re-bases the ROB at start-up and skips lost heads.
module rob_drain_ctrl #(
  parameter int p_WORD_LEN = 16,
  parameter int p_PID_LEN  = 4,
  parameter int p_TIMEOUT  = 32,
  parameter int p_CNT_LEN  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [p_PID_LEN-1:0]  i_start_pid,
  output logic                  o_rob_reset,
  output logic [p_PID_LEN-1:0]  o_rob_reset_pid,
  input  logic [p_PID_LEN-1:0]  i_rob_min_pid,
  input  logic [p_PID_LEN-1:0]  i_rob_max_pid,
  input  logic [p_WORD_LEN-1:0] i_rob_out_data,
  input  logic                  i_rob_out_valid,
  output logic                  o_rob_out_en,
  output logic [p_WORD_LEN-1:0] o_data,
  output logic [p_PID_LEN-1:0]  o_pid,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_skip,
  output logic [p_CNT_LEN-1:0]  o_pkt_cnt,
  output logic [p_CNT_LEN-1:0]  o_drop_cnt
);

  localparam int TMO_W = (p_TIMEOUT > 1) ? $clog2(p_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(p_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_SKIP = 2'd2
  } state_t;

  state_t                state_q;
  logic                  rob_rst_q;
  logic [p_PID_LEN-1:0]  skip_pid_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [p_WORD_LEN-1:0] data_q;
  logic [p_PID_LEN-1:0]  pid_q;
  logic                  valid_q;
  logic                  skip_q;
  logic [p_CNT_LEN-1:0]  pkt_q;
  logic [p_CNT_LEN-1:0]  drop_q;

  logic                  pop;
  logic                  accept;
  logic                  missing;
  logic                  tmo_hit;
  logic [p_PID_LEN-1:0]  skip_pid_d;

  function automatic logic [p_CNT_LEN-1:0] sat_inc(input logic [p_CNT_LEN-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The output register frees up either when empty or when drained this same edge.
  assign pop     = (state_q == ST_RUN) & i_rob_out_valid & (~valid_q | i_ready);
  assign accept  = valid_q & i_ready;
  assign missing = (state_q == ST_RUN) & ~i_rob_out_valid &
                   (i_rob_max_pid != i_rob_min_pid);
  assign tmo_hit    = missing & (tmo_q == TMO_LAST);
  assign skip_pid_d = i_rob_min_pid + 1'b1;

  // INIT re-bases onto the live start PID so a mid-run reset picks up its current value.
  assign o_rob_out_en    = pop;
  assign o_rob_reset     = rob_rst_q;
  assign o_rob_reset_pid = (state_q == ST_INIT) ? i_start_pid : skip_pid_q;
  assign o_data          = data_q;
  assign o_pid           = pid_q;
  assign o_valid         = valid_q;
  assign o_skip          = skip_q;
  assign o_pkt_cnt       = pkt_q;
  assign o_drop_cnt      = drop_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_INIT;
      rob_rst_q  <= 1'b1;
      skip_pid_q <= '0;
      tmo_q      <= '0;
      data_q     <= '0;
      pid_q      <= '0;
      valid_q    <= 1'b0;
      skip_q     <= 1'b0;
      pkt_q      <= '0;
      drop_q     <= '0;
    end else begin
      rob_rst_q <= 1'b0;
      skip_q    <= 1'b0;

      if (pop) begin
        data_q  <= i_rob_out_data;
        pid_q   <= i_rob_min_pid;
        valid_q <= 1'b1;
        pkt_q   <= sat_inc(pkt_q);
      end else if (accept) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        ST_INIT: begin
          state_q <= ST_RUN;
          tmo_q   <= '0;
        end
        ST_RUN: begin
          if (tmo_hit) begin
            state_q    <= ST_SKIP;
            rob_rst_q  <= 1'b1;
            skip_q     <= 1'b1;
            skip_pid_q <= skip_pid_d;
            drop_q     <= sat_inc(drop_q);
            tmo_q      <= '0;
          end else if (missing) begin
            tmo_q <= tmo_q + 1'b1;
          end else begin
            tmo_q <= '0;
          end
        end
        ST_SKIP: begin
          state_q <= ST_RUN;
          tmo_q   <= '0;
        end
        default: begin
          state_q   <= ST_INIT;
          rob_rst_q <= 1'b1;
          tmo_q     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rob_drain_ctrl.sv
// Bench for rob_drain_ctrl: directed vector table, hand-written timeout/reset sequences,
// then randomized traffic checked every cycle against a behavioural model.
module tb_rob_drain_ctrl;

  localparam int WORD = 16;
  localparam int PIDW = 4;
  localparam int TMO  = 32;
  localparam int CNTW = 5;
  localparam int CNT_MAX = 31;

  logic            clk;
  logic            rst;
  logic [PIDW-1:0] start_pid;
  logic            rob_reset;
  logic [PIDW-1:0] rob_reset_pid;
  logic [PIDW-1:0] rob_min;
  logic [PIDW-1:0] rob_max;
  logic [WORD-1:0] rob_data;
  logic            rob_valid;
  logic            rob_out_en;
  logic [WORD-1:0] data;
  logic [PIDW-1:0] pid;
  logic            valid;
  logic            ready;
  logic            skip;
  logic [CNTW-1:0] pkt_cnt;
  logic [CNTW-1:0] drop_cnt;

  rob_drain_ctrl #(
    .p_WORD_LEN(WORD), .p_PID_LEN(PIDW), .p_TIMEOUT(TMO), .p_CNT_LEN(CNTW)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_start_pid(start_pid),
    .o_rob_reset(rob_reset), .o_rob_reset_pid(rob_reset_pid),
    .i_rob_min_pid(rob_min), .i_rob_max_pid(rob_max),
    .i_rob_out_data(rob_data), .i_rob_out_valid(rob_valid),
    .o_rob_out_en(rob_out_en), .o_data(data), .o_pid(pid), .o_valid(valid),
    .i_ready(ready), .o_skip(skip), .o_pkt_cnt(pkt_cnt), .o_drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Behavioural model: the controller seen as "first cycle after reset", "the cycle
  // after a loss was declared", or normal running, plus a count of consecutive
  // cycles the head has been missing while newer packets wait.
  bit              m_init, m_skip, m_valid, m_last_pop;
  logic [PIDW-1:0] m_skip_pid, m_pid;
  logic [WORD-1:0] m_data;
  int              m_pkt, m_drop, m_miss;

  typedef struct {
    bit v; logic [3:0] mn; logic [3:0] mx; logic [15:0] d; bit r;
    bit e_en; bit e_rst; bit e_vld; logic [3:0] e_pid; logic [15:0] e_data; int e_pkt;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(bit v, logic [3:0] mn, logic [3:0] mx, logic [15:0] d, bit r,
                              bit e_en, bit e_rst, bit e_vld, logic [3:0] e_pid,
                              logic [15:0] e_data, int e_pkt);
    vec_t t;
    t.v = v; t.mn = mn; t.mx = mx; t.d = d; t.r = r;
    t.e_en = e_en; t.e_rst = e_rst; t.e_vld = e_vld; t.e_pid = e_pid;
    t.e_data = e_data; t.e_pkt = e_pkt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_init = 1'b1; m_skip = 1'b0; m_valid = 1'b0; m_last_pop = 1'b0;
    m_skip_pid = '0; m_pid = '0; m_data = '0;
    m_pkt = 0; m_drop = 0; m_miss = 0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit v, input logic [3:0] mn, input logic [3:0] mx,
                      input logic [15:0] d, input bit r);
    bit run, pop, acc, later, nxt_skip;
    rob_valid = v; rob_min = mn; rob_max = mx; rob_data = d; ready = r;
    #1;
    run = !m_init && !m_skip;
    pop = run && v && (!m_valid || r);
    chk("rob_out_en", 32'(rob_out_en), 32'(pop));
    chk("rob_reset", 32'(rob_reset), 32'(m_init || m_skip));
    if (m_init) chk("rob_reset_pid_init", 32'(rob_reset_pid), 32'(start_pid));
    else if (m_skip) chk("rob_reset_pid_skip", 32'(rob_reset_pid), 32'(m_skip_pid));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("data", 32'(data), 32'(m_data));
    chk("pid", 32'(pid), 32'(m_pid));
    chk("skip", 32'(skip), 32'(m_skip));
    chk("pkt_cnt", 32'(pkt_cnt), m_pkt);
    chk("drop_cnt", 32'(drop_cnt), m_drop);

    acc   = m_valid && r;
    later = !v && (mx != mn);
    m_last_pop = pop;
    if (pop) begin
      m_valid = 1'b1; m_data = d; m_pid = mn;
      if (m_pkt < CNT_MAX) m_pkt++;
    end else if (acc) begin
      m_valid = 1'b0;
    end
    nxt_skip = 1'b0;
    if (run && later) begin
      m_miss++;
      if (m_miss >= TMO) begin
        nxt_skip = 1'b1;
        m_skip_pid = mn + 4'd1;
        if (m_drop < CNT_MAX) m_drop++;
        m_miss = 0;
      end
    end else begin
      m_miss = 0;
    end
    m_init = 1'b0;
    m_skip = nxt_skip;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] sp);
    rst = 1'b1;
    start_pid = sp;
    model_reset();
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pkt", 32'(pkt_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_skip", 32'(skip), 32'd0);
    chk("rst_rob_reset", 32'(rob_reset), 32'd1);
    chk("rst_rob_reset_pid", 32'(rob_reset_pid), 32'(sp));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic miss_run(input int n, input logic [3:0] mn, input logic [3:0] mx, input bit r);
    for (int k = 0; k < n; k++) step(1'b0, mn, mx, 16'h0, r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rmin;
    int vprob, rprob, occ;

    rst = 1'b1; start_pid = 4'd3; rob_min = '0; rob_max = '0;
    rob_data = '0; rob_valid = 1'b0; ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset(4'd3);

    // INIT cycle, back-to-back pops 3,4,5, then five cycles of backpressure.
    tbl[0]  = mk(1, 4'd3, 4'd6, 16'hA003, 1, 0, 1, 0, 4'd0, 16'h0000, 0);
    tbl[1]  = mk(1, 4'd3, 4'd6, 16'hA003, 1, 1, 0, 1, 4'd3, 16'hA003, 1);
    tbl[2]  = mk(1, 4'd4, 4'd6, 16'hA004, 1, 1, 0, 1, 4'd4, 16'hA004, 2);
    tbl[3]  = mk(1, 4'd5, 4'd6, 16'hA005, 1, 1, 0, 1, 4'd5, 16'hA005, 3);
    tbl[4]  = mk(0, 4'd6, 4'd6, 16'h0000, 1, 0, 0, 0, 4'd5, 16'hA005, 3);
    tbl[5]  = mk(1, 4'd6, 4'd8, 16'hB006, 0, 1, 0, 1, 4'd6, 16'hB006, 4);
    for (int i = 6; i <= 10; i++)
      tbl[i] = mk(1, 4'd7, 4'd8, 16'hB007, 0, 0, 0, 1, 4'd6, 16'hB006, 4);
    tbl[11] = mk(1, 4'd7, 4'd8, 16'hB007, 1, 1, 0, 1, 4'd7, 16'hB007, 5);
    tbl[12] = mk(0, 4'd8, 4'd8, 16'h0000, 1, 0, 0, 0, 4'd7, 16'hB007, 5);

    for (int i = 0; i < 13; i++) begin
      rob_valid = tbl[i].v; rob_min = tbl[i].mn; rob_max = tbl[i].mx;
      rob_data = tbl[i].d; ready = tbl[i].r;
      #1;
      chk($sformatf("tbl%0d_en", i), 32'(rob_out_en), 32'(tbl[i].e_en));
      chk($sformatf("tbl%0d_rob_reset", i), 32'(rob_reset), 32'(tbl[i].e_rst));
      step(tbl[i].v, tbl[i].mn, tbl[i].mx, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_pid", i), 32'(pid), 32'(tbl[i].e_pid));
      chk($sformatf("tbl%0d_data", i), 32'(data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_pkt", i), 32'(pkt_cnt), tbl[i].e_pkt);
    end

    // Head 6 missing with 7..9 buffered: loss declared after 32 missing cycles.
    miss_run(TMO - 1, 4'd6, 4'd9, 1'b1);
    chk("tmo_no_early_skip", 32'(skip), 32'd0);
    miss_run(1, 4'd6, 4'd9, 1'b1);
    chk("tmo_skip", 32'(skip), 32'd1);
    chk("tmo_rob_reset", 32'(rob_reset), 32'd1);
    chk("tmo_reset_pid", 32'(rob_reset_pid), 32'd7);
    chk("tmo_drop", 32'(drop_cnt), 32'd1);
    step(1'b0, 4'd7, 4'd9, 16'h0, 1'b1);
    chk("tmo_skip_pulse_end", 32'(skip), 32'd0);

    // Head arrives on the 20th cycle: no loss, and the count restarts afterwards.
    miss_run(19, 4'd7, 4'd9, 1'b1);
    step(1'b1, 4'd7, 4'd9, 16'hC007, 1'b1);
    chk("late_head_pid", 32'(pid), 32'd7);
    miss_run(TMO - 1, 4'd8, 4'd9, 1'b1);
    chk("late_head_no_skip", 32'(skip), 32'd0);
    chk("late_head_drop", 32'(drop_cnt), 32'd1);
    miss_run(1, 4'd8, 4'd9, 1'b1);
    chk("late_head_skip", 32'(skip), 32'd1);
    chk("late_head_reset_pid", 32'(rob_reset_pid), 32'd9);
    step(1'b0, 4'd9, 4'd9, 16'h0, 1'b1);

    // Lost head 15 wraps the re-base PID to 0.
    miss_run(TMO, 4'd15, 4'd2, 1'b1);
    chk("wrap_skip", 32'(skip), 32'd1);
    chk("wrap_reset_pid", 32'(rob_reset_pid), 32'd0);
    chk("wrap_drop", 32'(drop_cnt), 32'd3);
    step(1'b0, 4'd0, 4'd2, 16'h0, 1'b1);

    // Reset while a packet is held and the missing count is at 10.
    step(1'b1, 4'd0, 4'd3, 16'hD000, 1'b0);
    miss_run(10, 4'd1, 4'd3, 1'b0);
    chk("midrst_pre_valid", 32'(valid), 32'd1);
    do_reset(4'd9);
    step(1'b0, 4'd1, 4'd3, 16'h0, 1'b0);
    miss_run(TMO - 1, 4'd1, 4'd3, 1'b0);
    chk("midrst_no_skip", 32'(skip), 32'd0);
    miss_run(1, 4'd1, 4'd3, 1'b0);
    chk("midrst_skip", 32'(skip), 32'd1);
    chk("midrst_reset_pid", 32'(rob_reset_pid), 32'd2);
    step(1'b0, 4'd2, 4'd3, 16'h0, 1'b0);

    // Counter saturation.
    for (int k = 0; k < 32; k++) begin
      miss_run(TMO, 4'd2, 4'd5, 1'b1);
      step(1'b0, 4'd3, 4'd5, 16'h0, 1'b1);
    end
    chk("drop_saturated", 32'(drop_cnt), 32'd31);
    for (int k = 0; k < 40; k++) step(1'b1, 4'(k), 4'(k + 2), 16'(k), 1'b1);
    chk("pkt_saturated", 32'(pkt_cnt), 32'd31);

    // Randomized traffic from a toy ROB whose head advances on pops and skips.
    do_reset(4'd5);
    rmin = 4'd5; vprob = 50; rprob = 50; occ = 2;
    for (int c = 0; c < 3000; c++) begin
      bit v, r;
      if (c % 48 == 0) begin
        case ($urandom_range(0, 3))
          0: vprob = 0;
          1: vprob = 10;
          2: vprob = 60;
          default: vprob = 95;
        endcase
        rprob = $urandom_range(0, 100);
        occ = $urandom_range(0, 5);
      end
      if ($urandom_range(0, 999) == 0) begin
        do_reset(4'($urandom));
        rmin = start_pid;
      end
      v = ($urandom_range(0, 99) < vprob);
      r = ($urandom_range(0, 99) < rprob);
      step(v, rmin, rmin + 4'(occ), 16'($urandom), r);
      if (m_last_pop) rmin = rmin + 4'd1;
      else if (m_skip) rmin = m_skip_pid;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
